instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Inverse of the pipeline control-unit decoder: takes decoded instruction fields (kind, rs, rt, rd, imm16, imm26) and assembles the 32-bit MIPS machine word.
- Streams encoded words into the instruction-memory write port at consecutive byte addresses from PC_BASE.
- Used by the testbench/loader path to build programs for the P5 pipeline without hand-assembled hex.
- Contains a 2-entry buffer with valid/ready on both sides.

Parameters:
- PC_BASE, 32'h0000_3000, byte address of the first written word.
- DEPTH, 4096, instruction-memory capacity in words.
- ADDR_W, 32, width of im_addr.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-low reset.
- flush  in  1  restart the program: clear the buffer, rewind the address, clear err.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder can accept a bundle.
- in_kind  in  5  instruction kind code (package constants).
- in_rs  in  5  rs field.
- in_rt  in  5  rt field.
- in_rd  in  5  rd field.
- in_imm16  in  16  immediate / branch offset.
- in_imm26  in  26  jump index.
- im_we  out  1  write request to instruction memory.
- im_ready  in  1  memory accepts a write this cycle.
- im_addr  out  ADDR_W  byte address of the current write.
- im_wdata  out  32  encoded word.
- count  out  13  number of words written since reset or flush.
- mem_full  out  1  DEPTH words written.
- err  out  1  sticky flag: an illegal kind was seen.

Behaviour:
- Reset (reset==0 at a clk edge) and flush both give:
  - buffer empty, im_we=0, im_addr=PC_BASE, im_wdata=0;
  - count=0, mem_full=0, err=0, in_ready=1 after the edge.
- Flush has priority over any accept or pop in the same cycle; those transfers are discarded.
- Reset overrides flush.
- Accept: occurs when in_valid & in_ready at an edge.
  - Encoding is combinational from the inputs; the word is pushed into the buffer tail.
- Encodings:
  - ADD: {000000, rs, rt, rd, 00000, 100000}
  - SUB: same as ADD with func 100010.
  - JR: {000000, rs, 15'b0, 001000}
  - ORI: {001101, rs, rt, imm16}
  - LUI: {001111, 00000, rt, imm16}; in_rs is ignored.
  - LW: {100011, rs, rt, imm16}
  - SW: {101011, rs, rt, imm16}
  - BEQ: {000100, rs, rt, imm16}
  - JAL: {000011, imm26}
  - NOP: 32'b0
- Illegal kind (any other code): the bundle is accepted (handshake completes) but nothing is pushed; err is set next cycle and stays set until reset or flush.
- Buffer: 2 entries, FIFO order.
  - in_ready = (entries<2) & ~mem_full.
  - Push and pop in the same cycle are allowed; the occupancy stays unchanged.
- Output:
  - im_we = (entries>0) & ~mem_full.
  - im_wdata = head entry.
  - A write completes when im_we & im_ready at an edge. On completion: pop the head, im_addr += 4, count += 1.
- Latency: a bundle accepted at edge N gives im_we=1 with that word during cycle N+1 at the earliest (registered buffer, no bypass).
- Backpressure: while im_ready=0, im_we/im_addr/im_wdata hold stable.
- Full:
  - When count reaches DEPTH, mem_full=1 and im_we=0.
  - Buffered entries are retained but not written.
  - in_ready=0; only flush or reset recovers.
  - No address wrap-around ever occurs.
- im_addr is always PC_BASE + 4*count.

Decomposition:
- Shared package/header `const.v`:
  - kind codes KIND_ADD=0, SUB=1, ORI=2, LUI=3, LW=4, SW=5, BEQ=6, JAL=7, JR=8, NOP=9;
  - opcode/func constants matching the decoder (R, LW, SW, BEQ, LUI, ORI, JAL, ADD, SUB, JR), so that encoder and decoder share one table.
- One sub-module: instr_word_fmt, a purely combinational kind+fields → 32-bit word + illegal flag.
- The top level holds the buffer, address counter, full logic and handshakes.

Test Plan:
- Encode one bundle each with im_ready=1 → im_wdata sequence:
  - ADD rs=1 rt=2 rd=3 → 0x00221820
  - ORI rs=0 rt=1 imm=0x1234 → 0x34011234
  - LUI rt=2 imm=0xFFFF → 0x3C02FFFF
  - LW rs=1 rt=4 imm=8 → 0x8C240008
  - SW → 0xAC240008
  - BEQ rs=1 rt=2 imm=0xFFFF → 0x1022FFFF
  - JAL imm26=0xC00 → 0x0C000C00
  - JR rs=31 → 0x03E00008
  - Addresses run 0x3000, 0x3004, … 0x301C; count=8.
- Hold im_ready=0 and drive 3 valid bundles back-to-back → the first 2 are accepted, in_ready=0 on the 3rd, outputs are stable. Release im_ready → words are written in order, then the 3rd is accepted.
- in_kind=31 followed by ADD → err=1, only the ADD is written at 0x3000, count=1.
- DEPTH=4: write 4 words, then offer 2 more → mem_full=1 after the 4th; the 5th sits buffered with im_we=0 and in_ready=0; assert flush → im_addr=0x3000, count=0, mem_full=0.
- Assert flush in the same cycle as an accept and a write → neither takes effect; buffer empty, count=0.
- Drop reset low for one edge mid-stream with 2 entries buffered → all outputs return to reset values on the next cycle.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// Shared kind codes and MIPS opcode/func constants for the encoder and decoder.
package instr_encoder_pkg;

  localparam logic [4:0] KIND_ADD = 5'd0;
  localparam logic [4:0] KIND_SUB = 5'd1;
  localparam logic [4:0] KIND_ORI = 5'd2;
  localparam logic [4:0] KIND_LUI = 5'd3;
  localparam logic [4:0] KIND_LW  = 5'd4;
  localparam logic [4:0] KIND_SW  = 5'd5;
  localparam logic [4:0] KIND_BEQ = 5'd6;
  localparam logic [4:0] KIND_JAL = 5'd7;
  localparam logic [4:0] KIND_JR  = 5'd8;
  localparam logic [4:0] KIND_NOP = 5'd9;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_LUI = 6'b001111;
  localparam logic [5:0] OP_ORI = 6'b001101;
  localparam logic [5:0] OP_JAL = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
    return {OP_R, rs, rt, rd, 5'b00000, fn};
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/instr_word_fmt.sv
// Combinational formatter: instruction kind plus fields to a 32-bit MIPS word.
module instr_word_fmt
  import instr_encoder_pkg::*;
(
  input  logic [4:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm16,
  input  logic [25:0] imm26,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    word    = 32'h0;
    illegal = 1'b0;
    case (kind)
      KIND_ADD: word = r_word(rs, rt, rd, FN_ADD);
      KIND_SUB: word = r_word(rs, rt, rd, FN_SUB);
      KIND_JR:  word = {OP_R, rs, 15'b0, FN_JR};
      KIND_ORI: word = i_word(OP_ORI, rs, rt, imm16);
      KIND_LUI: word = i_word(OP_LUI, 5'b00000, rt, imm16);
      KIND_LW:  word = i_word(OP_LW, rs, rt, imm16);
      KIND_SW:  word = i_word(OP_SW, rs, rt, imm16);
      KIND_BEQ: word = i_word(OP_BEQ, rs, rt, imm16);
      KIND_JAL: word = {OP_JAL, imm26};
      KIND_NOP: word = 32'h0;
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Encodes field bundles into MIPS words and streams them through a 2-entry
// buffer into the instruction-memory write port at consecutive byte addresses.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter logic [31:0] PC_BASE = 32'h0000_3000,
  parameter int          DEPTH   = 4096,
  parameter int          ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm16,
  input  logic [25:0]       in_imm26,
  output logic              im_we,
  input  logic              im_ready,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic [12:0]       count,
  output logic              mem_full,
  output logic              err
);

  localparam logic [12:0] DEPTH_C = 13'(DEPTH);

  logic [31:0] fmt_word;
  logic        fmt_illegal;
  logic [31:0] buf_q [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  entries;
  logic        accept;
  logic        push;
  logic        pop;

  instr_word_fmt u_fmt (
    .kind    (in_kind),
    .rs      (in_rs),
    .rt      (in_rt),
    .rd      (in_rd),
    .imm16   (in_imm16),
    .imm26   (in_imm26),
    .word    (fmt_word),
    .illegal (fmt_illegal)
  );

  // Handshake: a transfer happens on a side exactly when its valid and ready are
  // both high at a rising edge; illegal bundles complete the handshake but are dropped.
  assign mem_full = (count == DEPTH_C);
  assign in_ready = (entries < 2'd2) & ~mem_full;
  assign im_we    = (entries != 2'd0) & ~mem_full;
  assign im_wdata = buf_q[rd_ptr];
  assign accept   = in_valid & in_ready;
  assign push     = accept & ~fmt_illegal;
  assign pop      = im_we & im_ready;

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      buf_q[0] <= 32'h0;
      buf_q[1] <= 32'h0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      entries  <= 2'd0;
      im_addr  <= ADDR_W'(PC_BASE);
      count    <= 13'd0;
      err      <= 1'b0;
    end else begin
      if (push) begin
        buf_q[wr_ptr] <= fmt_word;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr  <= ~rd_ptr;
        im_addr <= im_addr + ADDR_W'(4);
        count   <= count + 13'd1;
      end
      case ({push, pop})
        2'b10:   entries <= entries + 2'd1;
        2'b01:   entries <= entries - 2'd1;
        default: entries <= entries;
      endcase
      if (accept && fmt_illegal) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_instr_encoder;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [4:0]  in_kind;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [15:0] in_imm16;
  logic [25:0] in_imm26;
  logic        im_ready;

  logic        in_ready_a, im_we_a, mem_full_a, err_a;
  logic [31:0] im_addr_a, im_wdata_a;
  logic [12:0] count_a;
  logic        in_ready_b, im_we_b, mem_full_b, err_b;
  logic [31:0] im_addr_b, im_wdata_b;
  logic [12:0] count_b;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] wr_q[$];
  logic [31:0] wa_q[$];
  int          m_cnt = 0;
  logic        m_err = 1'b0;
  logic        m_acc, m_pop, m_ready, m_we;
  logic        mon_on  = 1'b0;
  logic        rand_on = 1'b0;

  instr_encoder u_dut_a (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_imm16(in_imm16), .in_imm26(in_imm26), .im_we(im_we_a), .im_ready(im_ready),
    .im_addr(im_addr_a), .im_wdata(im_wdata_a), .count(count_a), .mem_full(mem_full_a),
    .err(err_a)
  );

  instr_encoder #(.DEPTH(4)) u_dut_b (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_imm16(in_imm16), .in_imm26(in_imm26), .im_we(im_we_b), .im_ready(im_ready),
    .im_addr(im_addr_b), .im_wdata(im_wdata_b), .count(count_b), .mem_full(mem_full_b),
    .err(err_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference encoding written straight from the instruction formats.
  function automatic logic [31:0] ref_word(input logic [4:0] k, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [4:0] rd,
                                           input logic [15:0] i16, input logic [25:0] i26);
    case (k)
      5'd0:    return {6'h00, rs, rt, rd, 5'd0, 6'h20};
      5'd1:    return {6'h00, rs, rt, rd, 5'd0, 6'h22};
      5'd2:    return {6'h0D, rs, rt, i16};
      5'd3:    return {6'h0F, 5'd0, rt, i16};
      5'd4:    return {6'h23, rs, rt, i16};
      5'd5:    return {6'h2B, rs, rt, i16};
      5'd6:    return {6'h04, rs, rt, i16};
      5'd7:    return {6'h03, i26};
      5'd8:    return {6'h00, rs, 15'd0, 6'h08};
      default: return 32'h0;
    endcase
  endfunction

  // scoreboard: model evaluated at the negedge ahead of each rising edge
  always @(negedge clk) begin
    if (mon_on) begin
      m_ready = (exp_q.size() < 2) && (m_cnt < 4096);
      m_we    = (exp_q.size() > 0) && (m_cnt < 4096);
      check("in_ready", 32'(in_ready_a), 32'(m_ready));
      check("im_we", 32'(im_we_a), 32'(m_we));
      check("count", 32'(count_a), 32'(m_cnt));
      check("im_addr", im_addr_a, 32'h3000 + 32'(4 * m_cnt));
      check("err", 32'(err_a), 32'(m_err));
      check("mem_full", 32'(mem_full_a), 32'(m_cnt == 4096));
      if (m_we) check("im_wdata", im_wdata_a, exp_q[0]);
      if (!reset || flush) begin
        exp_q.delete();
        wr_q.delete();
        wa_q.delete();
        m_cnt = 0;
        m_err = 1'b0;
      end else begin
        m_acc = in_valid && m_ready;
        m_pop = m_we && im_ready;
        if (m_pop) begin
          wr_q.push_back(im_wdata_a);
          wa_q.push_back(im_addr_a);
          void'(exp_q.pop_front());
          m_cnt++;
        end
        if (m_acc) begin
          if (in_kind <= 5'd9) exp_q.push_back(ref_word(in_kind, in_rs, in_rt, in_rd, in_imm16, in_imm26));
          else m_err = 1'b1;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rand_on) begin
      #1;
      im_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // driver tasks: called aligned just after a rising edge
  task automatic send(input logic [4:0] k, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [15:0] i16, input logic [25:0] i26);
    int n = 0;
    in_kind = k; in_rs = rs; in_rt = rt; in_rd = rd; in_imm16 = i16; in_imm26 = i26;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready_a && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready_a) check("send_timeout", 32'(in_ready_a), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string pfx);
    @(negedge clk);
    check({pfx, "_im_we"}, 32'(im_we_a), 32'd0);
    check({pfx, "_im_addr"}, im_addr_a, 32'h3000);
    check({pfx, "_im_wdata"}, im_wdata_a, 32'h0);
    check({pfx, "_count"}, 32'(count_a), 32'd0);
    check({pfx, "_mem_full"}, 32'(mem_full_a), 32'd0);
    check({pfx, "_err"}, 32'(err_a), 32'd0);
    check({pfx, "_in_ready"}, 32'(in_ready_a), 32'd1);
    @(posedge clk); #1;
  endtask

  logic [31:0] t1_words [8] = '{32'h00221820, 32'h34011234, 32'h3C02FFFF, 32'h8C240008,
                                32'hAC240008, 32'h1022FFFF, 32'h0C000C00, 32'h03E00008};

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; im_ready = 1'b0;
    in_kind = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm16 = '0; in_imm26 = '0;
    repeat (2) @(posedge clk);
    #1; mon_on = 1'b1;
    check_reset_vals("rst");
    reset = 1'b1;

    // one bundle of each main kind
    im_ready = 1'b1;
    send(5'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    send(5'd2, 5'd0, 5'd1, 5'd0, 16'h1234, 26'h0);
    send(5'd3, 5'd7, 5'd2, 5'd0, 16'hFFFF, 26'h0);
    send(5'd4, 5'd1, 5'd4, 5'd0, 16'h0008, 26'h0);
    send(5'd5, 5'd1, 5'd4, 5'd0, 16'h0008, 26'h0);
    send(5'd6, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0);
    send(5'd7, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000C00);
    send(5'd8, 5'd31, 5'd0, 5'd0, 16'h0, 26'h0);
    idle(3);
    check("t1_count", 32'(count_a), 32'd8);
    check("t1_nwrites", 32'(wr_q.size()), 32'd8);
    for (int i = 0; i < 8 && i < wr_q.size(); i++) begin
      check("t1_word", wr_q[i], t1_words[i]);
      check("t1_addr", wa_q[i], 32'h3000 + 32'(4 * i));
    end

    // backpressure: two fill the buffer, third is held off
    do_flush();
    im_ready = 1'b0;
    send(5'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    send(5'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    in_kind = 5'd2; in_rs = 5'd0; in_rt = 5'd1; in_imm16 = 16'h1234; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready_a), 32'd0);
      check("bp_im_we", 32'(im_we_a), 32'd1);
      check("bp_addr", im_addr_a, 32'h3000);
      check("bp_wdata", im_wdata_a, 32'h00221820);
    end
    @(posedge clk); #1;
    im_ready = 1'b1;
    begin
      int n = 0;
      @(negedge clk);
      while (!in_ready_a && n < 50) begin @(negedge clk); n++; end
      check("bp_third_ready", 32'(in_ready_a), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    idle(4);
    check("bp_nwrites", 32'(wr_q.size()), 32'd3);
    if (wr_q.size() == 3) begin
      check("bp_w0", wr_q[0], 32'h00221820);
      check("bp_w1", wr_q[1], 32'h00221822);
      check("bp_w2", wr_q[2], 32'h34011234);
    end

    // illegal kind then ADD
    do_flush();
    send(5'd31, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    send(5'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    idle(3);
    check("ill_err", 32'(err_a), 32'd1);
    check("ill_count", 32'(count_a), 32'd1);
    check("ill_nwrites", 32'(wr_q.size()), 32'd1);
    if (wr_q.size() == 1) begin
      check("ill_word", wr_q[0], 32'h00221820);
      check("ill_addr", wa_q[0], 32'h3000);
    end

    // full behaviour on the DEPTH=4 instance
    do_flush();
    for (int i = 0; i < 4; i++) send(5'd0, 5'd1, 5'd2, 5'(i), 16'h0, 26'h0);
    send(5'd2, 5'd0, 5'd1, 5'd0, 16'h1234, 26'h0);
    send(5'd3, 5'd0, 5'd2, 5'd0, 16'hFFFF, 26'h0);
    idle(2);
    @(negedge clk);
    check("full_mem_full", 32'(mem_full_b), 32'd1);
    check("full_im_we", 32'(im_we_b), 32'd0);
    check("full_in_ready", 32'(in_ready_b), 32'd0);
    check("full_count", 32'(count_b), 32'd4);
    check("full_addr", im_addr_b, 32'h3010);
    check("full_held_word", im_wdata_b, 32'h34011234);
    @(posedge clk); #1;
    do_flush();
    @(negedge clk);
    check("full_fl_addr", im_addr_b, 32'h3000);
    check("full_fl_count", 32'(count_b), 32'd0);
    check("full_fl_mem_full", 32'(mem_full_b), 32'd0);
    check("full_fl_in_ready", 32'(in_ready_b), 32'd1);
    @(posedge clk); #1;

    // flush collides with an accept and a write
    im_ready = 1'b0;
    send(5'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    in_kind = 5'd1; in_valid = 1'b1; im_ready = 1'b1; flush = 1'b1;
    @(negedge clk);
    check("fc_pre_in_ready", 32'(in_ready_a), 32'd1);
    check("fc_pre_im_we", 32'(im_we_a), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    idle(1);
    @(negedge clk);
    check("fc_im_we", 32'(im_we_a), 32'd0);
    check("fc_count", 32'(count_a), 32'd0);
    check("fc_addr", im_addr_a, 32'h3000);
    @(posedge clk); #1;

    // reset mid-stream with two entries buffered and err set
    im_ready = 1'b0;
    send(5'd20, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
    send(5'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    send(5'd6, 5'd1, 5'd2, 5'd0, 16'h0010, 26'h0);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    check_reset_vals("mid_rst");

    // random traffic
    rand_on = 1'b1;
    for (int i = 0; i < 300; i++) begin
      int r;
      logic [4:0] k;
      idle($urandom_range(0, 2));
      if ($urandom_range(0, 39) == 0) begin
        do_flush();
      end else begin
        r = $urandom_range(0, 15);
        k = (r >= 11) ? ((r == 15) ? 5'($urandom_range(10, 31)) : 5'(r % 10)) : 5'(r);
        send(k, 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), 26'($urandom));
      end
    end
    rand_on = 1'b0;
    @(posedge clk); #2;
    im_ready = 1'b1;
    begin
      int n = 0;
      @(negedge clk);
      while (im_we_a && n < 50) begin @(negedge clk); n++; end
      check("drain_im_we", 32'(im_we_a), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
